conv_in_ctrl_multipass: RTL and testbench

//  Parametrised successor of the L1 conv input controller. Sequences line-buffer

---
 rtl/conv_in_ctrl_multipass_if.sv | 35 +++
 rtl/conv_in_ctrl_multipass.sv | 152 +++++++++++++++
 tb/tb_conv_in_ctrl_multipass.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_in_ctrl_multipass_if.sv
// Control bundle between the conv input sequencer and the SRAM/line-buffer side.
// The slave modport is the sequencer; master drives start/stall and observes outputs.
interface conv_in_ctrl_multipass_if #(
  parameter int ADDR_W    = 6,
  parameter int WT_ADDR_W = 9,
  parameter int WIN_W     = 5,
  parameter int PASS_W    = 4
);
  logic                 ConvValid_i;
  logic                 Stall_i;
  logic [ADDR_W-1:0]    DataRamAddr_o;
  logic [WT_ADDR_W-1:0] WtRamAddr_o;
  logic                 WtBufEn_o;
  logic                 InBufEn_o;
  logic                 InBufZero_o;
  logic                 WinMuxZero_o;
  logic [WIN_W-1:0]     ConvWinCnt_o;
  logic [PASS_W-1:0]    PassCnt_o;
  logic                 vbit_o;
  logic                 Done_o;

  modport slave (
    input  ConvValid_i, Stall_i,
    output DataRamAddr_o, WtRamAddr_o, WtBufEn_o, InBufEn_o,
    output InBufZero_o, WinMuxZero_o, ConvWinCnt_o, PassCnt_o,
    output vbit_o, Done_o
  );

  modport master (
    output ConvValid_i, Stall_i,
    input  DataRamAddr_o, WtRamAddr_o, WtBufEn_o, InBufEn_o,
    input  InBufZero_o, WinMuxZero_o, ConvWinCnt_o, PassCnt_o,
    input  vbit_o, Done_o
  );
endinterface

// File: rtl/conv_in_ctrl_multipass.sv
// Multi-pass conv input sequencer: per-pass line/weight preload, then
// per-window streaming with bottom zero-padding and column-pad flags.
module conv_in_ctrl_multipass #(
  parameter int WIN_CNT   = 24,
  parameter int NUM_LINES = 50,
  parameter int INI_LINES = 2,
  parameter int OUT_ROWS  = 50,
  parameter int NUM_PASS  = 1,
  parameter int PAD_COL   = 1,
  parameter int ADDR_W    = 6,
  parameter int WT_ADDR_W = 9,
  parameter int WIN_W     = 5,
  parameter int PASS_W    = 4
) (
  input logic clk,
  input logic rst,
  conv_in_ctrl_multipass_if.slave io
);
  localparam int INI_W = (INI_LINES > 0) ? $clog2(INI_LINES + 1) : 1;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  localparam logic [INI_W-1:0]  INI_LAST  = INI_W'(INI_LINES);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CNT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT_ROWS - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);

  typedef enum logic [1:0] {IDLE, INI, WORK, SDB} state_t;

  state_t            state, state_n;
  logic [INI_W-1:0]  ini_cnt, ini_n;
  logic [WIN_W-1:0]  win_cnt, win_n;
  logic [ROW_W-1:0]  row_cnt, row_n;
  logic [PASS_W-1:0] pass_cnt, pass_n;
  logic              ib_en, ib_en_n;
  logic              wmz, wmz_n;
  logic              cv, stall, work, row_load, in_buf_en, pad_row;
  int                line;

  assign cv    = io.ConvValid_i;
  assign stall = io.Stall_i;
  assign work  = (state == WORK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ini_cnt  <= '0;
      win_cnt  <= '0;
      row_cnt  <= '0;
      pass_cnt <= '0;
      ib_en    <= 1'b0;
      wmz      <= 1'b0;
    end else begin
      state    <= state_n;
      ini_cnt  <= ini_n;
      win_cnt  <= win_n;
      row_cnt  <= row_n;
      pass_cnt <= pass_n;
      ib_en    <= ib_en_n;
      wmz      <= wmz_n;
    end
  end

  always_comb begin
    state_n = state;
    ini_n   = ini_cnt;
    win_n   = win_cnt;
    row_n   = row_cnt;
    pass_n  = pass_cnt;
    unique case (state)
      IDLE: if (cv) state_n = INI;
      INI: begin
        if (!cv) begin
          state_n = IDLE;
          ini_n   = '0;
          pass_n  = '0;
        end else if (!stall) begin
          if (ini_cnt == INI_LAST) begin
            state_n = WORK;
            ini_n   = '0;
          end else begin
            ini_n = ini_cnt + 1'b1;
          end
        end
      end
      WORK: begin
        if (!cv) begin
          state_n = IDLE;
          win_n   = '0;
          row_n   = '0;
          pass_n  = '0;
        end else if (!stall) begin
          if (win_cnt != WIN_LAST) begin
            win_n = win_cnt + 1'b1;
          end else begin
            win_n = '0;
            if (row_cnt != ROW_LAST) begin
              row_n = row_cnt + 1'b1;
            end else begin
              row_n = '0;
              if (pass_cnt == PASS_LAST) begin
                state_n = SDB;
              end else begin
                state_n = INI;
                pass_n  = pass_cnt + 1'b1;
              end
            end
          end
        end
      end
      SDB: begin
        if (!cv) begin
          state_n = IDLE;
          pass_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // Registered enables are computed from next-cycle values so they line up.
    ib_en_n = (state == INI) && cv && !stall && (ini_cnt != INI_LAST);
    wmz_n   = (PAD_COL != 0) && (state_n == WORK)
              && ((win_n == '0) || (win_n == WIN_LAST));
  end

  always_comb begin
    line             = INI_LINES + int'(row_cnt);
    pad_row          = (line >= NUM_LINES);
    io.DataRamAddr_o = '0;
    io.WtRamAddr_o   = '0;
    unique case (state)
      INI: begin
        io.DataRamAddr_o = ADDR_W'(ini_cnt);
        io.WtRamAddr_o   = WT_ADDR_W'(int'(pass_cnt) * INI_LINES
                                      + int'(ini_cnt));
      end
      WORK: io.DataRamAddr_o = ADDR_W'(pad_row ? NUM_LINES - 1 : line);
      default: ;
    endcase
  end

  assign row_load  = work && (win_cnt == WIN_LAST) && !stall
                     && (row_cnt != ROW_LAST);
  assign in_buf_en = ib_en || row_load;

  assign io.WtBufEn_o    = ib_en;
  assign io.InBufEn_o    = in_buf_en;
  assign io.InBufZero_o  = in_buf_en && work && pad_row;
  assign io.WinMuxZero_o = wmz;
  assign io.ConvWinCnt_o = win_cnt;
  assign io.PassCnt_o    = pass_cnt;
  assign io.vbit_o       = work && !stall;
  assign io.Done_o       = (state == SDB);
endmodule

// File: tb/tb_conv_in_ctrl_multipass.sv
// Scoreboard bench: one DUT at default parameters, one with three passes.
// Expected windows are queued from the layer geometry and popped on vbit_o.
module tb_conv_in_ctrl_multipass;
  localparam int WIN_CNT   = 24;
  localparam int NUM_LINES = 50;
  localparam int INI_LINES = 2;
  localparam int OUT_ROWS  = 50;
  localparam int PASS_LEN  = INI_LINES + 1 + OUT_ROWS * WIN_CNT;

  typedef struct packed {
    logic [3:0] pass;
    logic [4:0] win;
    logic [5:0] addr;
    logic       inbuf;
    logic       zero;
    logic       wmz;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  win_t qa[$];
  win_t qb[$];

  conv_in_ctrl_multipass_if a ();
  conv_in_ctrl_multipass_if b ();

  conv_in_ctrl_multipass dut_a (
    .clk (clk),
    .rst (rst),
    .io  (a)
  );

  conv_in_ctrl_multipass #(.NUM_PASS(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .io  (b)
  );

  always #5 clk = ~clk;

  wire [29:0] a_outs = {a.DataRamAddr_o, a.WtRamAddr_o, a.WtBufEn_o,
                        a.InBufEn_o, a.InBufZero_o, a.WinMuxZero_o,
                        a.ConvWinCnt_o, a.PassCnt_o, a.vbit_o, a.Done_o};
  wire [29:0] b_outs = {b.DataRamAddr_o, b.WtRamAddr_o, b.WtBufEn_o,
                        b.InBufEn_o, b.InBufZero_o, b.WinMuxZero_o,
                        b.ConvWinCnt_o, b.PassCnt_o, b.vbit_o, b.Done_o};

  // per-run observations of DUT a
  int          st_first_v, st_nv, st_nib, st_nz, st_done, st_ndone;
  logic [29:0] st_post_abort;
  logic [14:0] st_ini[$];
  logic [12:0] st_frz[$];

  always @(negedge clk) begin
    if (!rst && a.vbit_o) begin
      win_t got, exp;
      got = '{a.PassCnt_o, a.ConvWinCnt_o, a.DataRamAddr_o,
              a.InBufEn_o, a.InBufZero_o, a.WinMuxZero_o};
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL a_window: unexpected window got %h, none expected", got);
      end else begin
        exp = qa.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL a_window: got p=%0d w=%0d ad=%0d ib=%b z=%b wmz=%b exp p=%0d w=%0d ad=%0d ib=%b z=%b wmz=%b",
                   got.pass, got.win, got.addr, got.inbuf, got.zero, got.wmz,
                   exp.pass, exp.win, exp.addr, exp.inbuf, exp.zero, exp.wmz);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b.vbit_o) begin
      win_t got, exp;
      got = '{b.PassCnt_o, b.ConvWinCnt_o, b.DataRamAddr_o,
              b.InBufEn_o, b.InBufZero_o, b.WinMuxZero_o};
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL b_window: unexpected window got %h, none expected", got);
      end else begin
        exp = qb.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL b_window: got p=%0d w=%0d ad=%0d ib=%b z=%b wmz=%b exp p=%0d w=%0d ad=%0d ib=%b z=%b wmz=%b",
                   got.pass, got.win, got.addr, got.inbuf, got.zero, got.wmz,
                   exp.pass, exp.win, exp.addr, exp.inbuf, exp.zero, exp.wmz);
        end
      end
    end
  end

  task automatic push_expected(input bit to_b, input int npass, input int count);
    win_t e;
    int   pushed = 0;
    for (int p = 0; p < npass; p++)
      for (int r = 0; r < OUT_ROWS; r++)
        for (int w = 0; w < WIN_CNT; w++) begin
          if (count >= 0 && pushed >= count) return;
          e.pass  = 4'(p);
          e.win   = 5'(w);
          e.addr  = 6'((INI_LINES + r > NUM_LINES - 1) ? NUM_LINES - 1 : INI_LINES + r);
          e.inbuf = (w == WIN_CNT - 1) && (r < OUT_ROWS - 1);
          e.zero  = e.inbuf && (INI_LINES + r >= NUM_LINES);
          e.wmz   = (w == 0) || (w == WIN_CNT - 1);
          if (to_b) qb.push_back(e);
          else qa.push_back(e);
          pushed++;
        end
  endtask

  // Drives DUT a from the cycle ConvValid_i rises (n=0) and records what it sees.
  task automatic run_a(input int stall_at, input int abort_at, input int max_n);
    st_first_v = -1; st_nv = 0; st_nib = 0; st_nz = 0;
    st_done = -1; st_ndone = 0; st_post_abort = '1;
    st_ini.delete();
    st_frz.delete();
    for (int n = 0; n < max_n; n++) begin
      @(posedge clk); #1;
      a.ConvValid_i = (abort_at < 0) || (n < abort_at);
      a.Stall_i = (stall_at >= 0) && (n >= stall_at) && (n < stall_at + 5);
      @(negedge clk);
      if (a.vbit_o) begin
        st_nv++;
        if (st_first_v < 0) st_first_v = n;
      end
      if (a.InBufEn_o) st_nib++;
      if (a.InBufZero_o) st_nz++;
      if (n == 1 || n == 2) st_ini.push_back({a.DataRamAddr_o, a.WtRamAddr_o});
      if (a.Stall_i)
        st_frz.push_back({a.ConvWinCnt_o, a.DataRamAddr_o, a.vbit_o, a.InBufEn_o});
      if (abort_at >= 0 && n == abort_at + 1) st_post_abort = a_outs;
      if (a.Done_o) begin
        st_ndone++;
        if (st_done < 0) st_done = n;
      end
      if (abort_at < 0 && st_done >= 0) break;
    end
    a.Stall_i = 1'b0;
  endtask

  task automatic drop_a();
    @(posedge clk); #1; a.ConvValid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (a_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_a: outputs %h, expected 0", a_outs);
    end
    vectors++;
    if (b_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_b: outputs %h, expected 0", b_outs);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (a_outs !== '0) begin
      miscompares++;
      $display("FAIL idle_a: outputs %h, expected 0", a_outs);
    end
  endtask

  task automatic test_full_run();
    push_expected(1'b0, 1, -1);
    run_a(-1, -1, 1400);
    vectors++;
    if (st_first_v !== 4) begin
      miscompares++;
      $display("FAIL first_vbit: cycle %0d, expected 4", st_first_v);
    end
    vectors++;
    if (st_nv !== 1200) begin
      miscompares++;
      $display("FAIL vbit_count: %0d, expected 1200", st_nv);
    end
    vectors++;
    if (st_nib !== 51) begin
      miscompares++;
      $display("FAIL inbuf_pulses: %0d, expected 51", st_nib);
    end
    vectors++;
    if (st_nz !== 1) begin
      miscompares++;
      $display("FAIL zero_pulses: %0d, expected 1", st_nz);
    end
    vectors++;
    if (st_done !== 1204) begin
      miscompares++;
      $display("FAIL done_cycle: %0d, expected 1204", st_done);
    end
    vectors++;
    if (st_ini.size() != 2 || st_ini[0] !== 15'd0 || st_ini[1] !== {6'd1, 9'd1}) begin
      miscompares++;
      $display("FAIL ini_addr: got %p, expected data/wt 0/0 then 1/1", st_ini);
    end
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL full_sb_drain: %0d windows left, expected 0", qa.size());
      qa.delete();
    end
    @(posedge clk); #1; a.ConvValid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (a.Done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL done_hold: Done_o %b, expected 1", a.Done_o);
    end
    @(negedge clk);
    vectors++;
    if (a_outs !== '0) begin
      miscompares++;
      $display("FAIL idle_after_done: outputs %h, expected 0", a_outs);
    end
  endtask

  task automatic test_multipass();
    int done_at = -1;
    int nwt = 0;
    push_expected(1'b1, 3, -1);
    for (int n = 0; n < 4000 && done_at < 0; n++) begin
      @(posedge clk); #1; b.ConvValid_i = 1'b1;
      @(negedge clk);
      if (b.WtBufEn_o) nwt++;
      if (n >= 1 && (n - 1) % PASS_LEN < INI_LINES && (n - 1) / PASS_LEN < 3) begin
        int p, k;
        p = (n - 1) / PASS_LEN;
        k = (n - 1) % PASS_LEN;
        vectors++;
        if ({b.DataRamAddr_o, b.WtRamAddr_o, b.PassCnt_o} !==
            {6'(k), 9'(p * INI_LINES + k), 4'(p)}) begin
          miscompares++;
          $display("FAIL mp_ini: pass %0d k %0d got data=%0d wt=%0d pc=%0d, expected data=%0d wt=%0d pc=%0d",
                   p, k, b.DataRamAddr_o, b.WtRamAddr_o, b.PassCnt_o,
                   k, p * INI_LINES + k, p);
        end
      end
      if (b.Done_o) done_at = n;
    end
    vectors++;
    if (done_at !== 1 + 3 * PASS_LEN) begin
      miscompares++;
      $display("FAIL mp_done_cycle: %0d, expected %0d", done_at, 1 + 3 * PASS_LEN);
    end
    vectors++;
    if (nwt !== 6) begin
      miscompares++;
      $display("FAIL mp_wt_pulses: %0d, expected 6", nwt);
    end
    vectors++;
    if (qb.size() != 0) begin
      miscompares++;
      $display("FAIL mp_sb_drain: %0d windows left, expected 0", qb.size());
      qb.delete();
    end
    @(posedge clk); #1; b.ConvValid_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (b_outs !== '0) begin
      miscompares++;
      $display("FAIL mp_idle: outputs %h, expected 0", b_outs);
    end
  endtask

  task automatic test_stall();
    push_expected(1'b0, 1, -1);
    run_a(4 + 3 * WIN_CNT + 10, -1, 1400);
    vectors++;
    if (st_frz.size() != 5) begin
      miscompares++;
      $display("FAIL stall_cycles: %0d, expected 5", st_frz.size());
    end
    foreach (st_frz[i]) begin
      vectors++;
      if (st_frz[i] !== {5'd10, 6'd5, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_frozen: cycle %0d got %h, expected %h",
                 i, st_frz[i], {5'd10, 6'd5, 1'b0, 1'b0});
      end
    end
    vectors++;
    if (st_done !== 1209 || st_nv !== 1200) begin
      miscompares++;
      $display("FAIL stall_length: done %0d vbits %0d, expected 1209 and 1200",
               st_done, st_nv);
    end
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL stall_sb_drain: %0d windows left, expected 0", qa.size());
      qa.delete();
    end
    drop_a();
  endtask

  task automatic test_abort();
    push_expected(1'b0, 1, 97);
    run_a(-1, 100, 131);
    vectors++;
    if (st_post_abort !== '0) begin
      miscompares++;
      $display("FAIL abort_idle: outputs %h, expected 0", st_post_abort);
    end
    vectors++;
    if (st_ndone !== 0) begin
      miscompares++;
      $display("FAIL abort_done: Done_o high %0d cycles, expected 0", st_ndone);
    end
    vectors++;
    if (st_nv !== 97 || qa.size() != 0) begin
      miscompares++;
      $display("FAIL abort_windows: %0d seen, %0d left, expected 97 and 0",
               st_nv, qa.size());
      qa.delete();
    end
  endtask

  task automatic test_reset_mid_ini();
    @(posedge clk); #1; a.ConvValid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    vectors++;
    if (a_outs !== '0) begin
      miscompares++;
      $display("FAIL rst_async: outputs %h, expected 0", a_outs);
    end
    a.ConvValid_i = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    push_expected(1'b0, 1, -1);
    run_a(-1, -1, 1400);
    vectors++;
    if (st_done !== 1204 || st_nv !== 1200 || st_nib !== 51) begin
      miscompares++;
      $display("FAIL rst_rerun: done %0d vbits %0d inbuf %0d, expected 1204 1200 51",
               st_done, st_nv, st_nib);
    end
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL rst_sb_drain: %0d windows left, expected 0", qa.size());
      qa.delete();
    end
    drop_a();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a.ConvValid_i = 1'b0;
    a.Stall_i = 1'b0;
    b.ConvValid_i = 1'b0;
    b.Stall_i = 1'b0;
    test_reset();
    test_full_run();
    test_multipass();
    test_stall();
    test_abort();
    test_reset_mid_ini();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
